// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the registered 1:4 demultiplexer.
//   NUM_CH  number of output channels
//   SEL_W   width of a channel select
//   ch_e    channel encodings A..D
//   next_ch round-robin successor, wrapping D -> A
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [SEL_W-1:0] {
    CH_A = 2'b00,
    CH_B = 2'b01,
    CH_C = 2'b10,
    CH_D = 2'b11
  } ch_e;

  // Natural 2-bit overflow gives the D -> A wrap.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return ch + SEL_W'(1);
  endfunction
endpackage

// File: rtl/demux_chan.sv
// demux_chan: one-entry output buffer for a single demux channel.
//   clk, rst_n  clock, async active-low reset
//   load_i      top accepted a word for this channel this cycle
//   data_i      word to load
//   out_rdy_i   consumer takes the buffered word this cycle
//   data_o      buffered word (held while empty, never cleared on drain)
//   vld_o       buffer holds a valid word
//   in_rdy_o    buffer can take a word: empty, or draining this cycle
module demux_chan
  import demux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
  input  logic         out_rdy_i,
  output logic [N-1:0] data_o,
  output logic         vld_o,
  output logic         in_rdy_o
);
  logic [N-1:0] data_q, data_d;
  logic         v_q, v_d;

  // A drain and a load in the same cycle keep the buffer full, which is
  // what gives one word per cycle per channel.
  assign in_rdy_o = ~v_q | out_rdy_i;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (v_q && out_rdy_i) v_d = 1'b0;
    if (load_i) begin
      v_d    = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = v_q;
endmodule

// File: rtl/demux1_4_buf.sv
// demux1_4_buf: registered 1-to-4 demultiplexer with valid/ready flow
// control. One producer word per cycle is steered into one of four
// one-entry channel buffers.
//   clk, rst_n          clock, async active-low reset
//   In, InV, S          input word, valid, destination select (00=A..11=D)
//   InRdy               selected channel can take In this cycle
//   OutA..OutD          channel data, straight from channel registers
//   OutVA..OutVD        channel holds a valid word
//   OutRdyA..OutRdyD    consumer takes the channel word this cycle
// Build option: define DEMUX_RR_EN to ignore S and select channels with a
// round-robin pointer that advances on every accept.
module demux1_4_buf
  import demux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] In,
  input  logic         InV,
  input  logic [1:0]   S,
  output logic         InRdy,
  output logic [N-1:0] OutA,
  output logic [N-1:0] OutB,
  output logic [N-1:0] OutC,
  output logic [N-1:0] OutD,
  output logic         OutVA,
  output logic         OutVB,
  output logic         OutVC,
  output logic         OutVD,
  input  logic         OutRdyA,
  input  logic         OutRdyB,
  input  logic         OutRdyC,
  input  logic         OutRdyD
);
  logic [SEL_W-1:0]            sel;
  logic                        accept;
  logic [NUM_CH-1:0]           load;
  logic [NUM_CH-1:0]           out_rdy;
  logic [NUM_CH-1:0]           vld;
  logic [NUM_CH-1:0]           in_rdy;
  logic [NUM_CH-1:0][N-1:0]    data;

`ifdef DEMUX_RR_EN
  logic [SEL_W-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = next_ch(rr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= CH_A;
    else        rr_q <= rr_d;
  end

  assign sel = rr_q;
`else
  assign sel = S;
`endif

  assign out_rdy = {OutRdyD, OutRdyC, OutRdyB, OutRdyA};

  // InRdy looks only at the targeted channel; a full channel never blocks
  // a different select on a later cycle.
  assign InRdy  = in_rdy[sel];
  assign accept = InV & InRdy;

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_CH; k++)
      load[k] = accept && (sel == SEL_W'(k));
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan #(.N(N)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load[k]),
      .data_i    (In),
      .out_rdy_i (out_rdy[k]),
      .data_o    (data[k]),
      .vld_o     (vld[k]),
      .in_rdy_o  (in_rdy[k])
    );
  end

  assign OutA  = data[CH_A];
  assign OutB  = data[CH_B];
  assign OutC  = data[CH_C];
  assign OutD  = data[CH_D];
  assign OutVA = vld[CH_A];
  assign OutVB = vld[CH_B];
  assign OutVC = vld[CH_C];
  assign OutVD = vld[CH_D];
endmodule

// File: tb/tb_demux1_4_buf.sv
module tb_demux1_4_buf;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] In;
  logic       InV;
  logic [1:0] S;
  logic       InRdy;
  logic [3:0] OutA, OutB, OutC, OutD;
  logic       OutVA, OutVB, OutVC, OutVD;
  logic       OutRdyA, OutRdyB, OutRdyC, OutRdyD;

  int n_tests = 0;
  int n_fail  = 0;

  demux1_4_buf #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .In(In), .InV(InV), .S(S), .InRdy(InRdy),
    .OutA(OutA), .OutB(OutB), .OutC(OutC), .OutD(OutD),
    .OutVA(OutVA), .OutVB(OutVB), .OutVC(OutVC), .OutVD(OutVD),
    .OutRdyA(OutRdyA), .OutRdyB(OutRdyB), .OutRdyC(OutRdyC), .OutRdyD(OutRdyD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // {valid, data} of channel k
  function automatic logic [4:0] chan(input int k);
    case (k)
      0:       return {OutVA, OutA};
      1:       return {OutVB, OutB};
      2:       return {OutVC, OutC};
      default: return {OutVD, OutD};
    endcase
  endfunction

  function automatic logic [3:0] all_v();
    return {OutVD, OutVC, OutVB, OutVA};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic [3:0] r);
    {OutRdyD, OutRdyC, OutRdyB, OutRdyA} = r;
  endtask

  initial begin
    rst_n = 1'b1; In = '0; InV = 1'b0; S = '0; set_rdy(4'b0000);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_v", all_v(), 4'b0000);
    chk("rst_d", {OutD, OutC, OutB, OutA}, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();

`ifndef DEMUX_RR_EN
    // 1: single routing to C
    In = 4'hA; S = 2'b10; InV = 1'b1;
    #1 chk("s1_inrdy", InRdy, 1'b1);
    tick();
    InV = 1'b0;
    chk("s1_c", chan(2), 5'h1A);
    chk("s1_v", all_v(), 4'b0100);
    S = 2'b00;
    #1 chk("s1_rdyA", InRdy, 1'b1);
    S = 2'b10;
    #1 chk("s1_rdyC", InRdy, 1'b0);

    // 2: backpressure on C, then retarget to B
    In = 4'h5; InV = 1'b1;
    #1 chk("s2_inrdy0", InRdy, 1'b0);
    tick();
    chk("s2_c_hold", chan(2), 5'h1A);
    chk("s2_b_empty", OutVB, 1'b0);
    S = 2'b01;
    #1 chk("s2_inrdyB", InRdy, 1'b1);
    tick();
    InV = 1'b0;
    chk("s2_b", chan(1), 5'h15);
    chk("s2_c", chan(2), 5'h1A);

    // 3: same-cycle drain and reload on C
    set_rdy(4'b0100); S = 2'b10; In = 4'h3; InV = 1'b1;
    #1 chk("s3_inrdy", InRdy, 1'b1);
    tick();
    InV = 1'b0;
    chk("s3_c", chan(2), 5'h13);
    set_rdy(4'b0110);
    tick();
    chk("s3_drain_c", chan(2), 5'h03);
    chk("s3_drain_b", chan(1), 5'h05);
    set_rdy(4'b0000);

    // 4: streaming, all consumers ready
    set_rdy(4'b1111);
    for (int i = 0; i < 8; i++) begin
      In = 4'(i); S = 2'(i % 4); InV = 1'b1;
      #1 chk($sformatf("s4_inrdy%0d", i), InRdy, 1'b1);
      tick();
      chk($sformatf("s4_out%0d", i), chan(i % 4), {1'b1, 4'(i)});
    end
    InV = 1'b0;
    tick();
    chk("s4_drained", all_v(), 4'b0000);
    chk("s4_last", {OutD, OutC, OutB, OutA}, 16'h7654);

    // 5: async reset with all channels full
    set_rdy(4'b0000);
    for (int k = 0; k < 4; k++) begin
      In = 4'(8 + k); S = 2'(k); InV = 1'b1;
      tick();
    end
    InV = 1'b0;
    chk("s5_full", all_v(), 4'b1111);
    chk("s5_data", {OutD, OutC, OutB, OutA}, 16'hBA98);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_v", all_v(), 4'b0000);
    chk("s5_rst_d", {OutD, OutC, OutB, OutA}, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    In = 4'hA; S = 2'b10; InV = 1'b1;
    #1 chk("s5_inrdy", InRdy, 1'b1);
    tick();
    InV = 1'b0;
    chk("s5_c", chan(2), 5'h1A);
    chk("s5_v", all_v(), 4'b0100);
`else
    // 6: round robin ignores S
    set_rdy(4'b1111); S = 2'b11;
    for (int i = 0; i < 5; i++) begin
      In = 4'(i + 1); InV = 1'b1;
      #1 chk($sformatf("s6_inrdy%0d", i), InRdy, 1'b1);
      tick();
      chk($sformatf("s6_out%0d", i), chan(i % 4), {1'b1, 4'(i + 1)});
    end
    // pointer now at B: fill B, C, then D with D stalled
    set_rdy(4'b0111);
    In = 4'h6; tick();
    In = 4'h7; tick();
    In = 4'h8; tick();
    chk("s6_d_full", chan(3), 5'h18);
    // go round A, B, C so the pointer returns to D while D is full
    In = 4'h9; tick();
    In = 4'hB; tick();
    In = 4'hC; tick();
    chk("s6_c", chan(2), 5'h1C);
    In = 4'hE;
    #1 chk("s6_stall", InRdy, 1'b0);
    tick(); tick();
    chk("s6_d_hold", chan(3), 5'h18);
    set_rdy(4'b1111);
    #1 chk("s6_unstall", InRdy, 1'b1);
    tick();
    chk("s6_d_new", chan(3), 5'h1E);
    In = 4'hF;
    tick();
    InV = 1'b0;
    chk("s6_wrap_a", chan(0), 5'h1F);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
